// File: rtl/pair_scan_ctrl.sv
// pair_scan_ctrl
// Runs one scan over a LEN-bit serial packet. Bits are pulled over a
// valid/ready handshake and non-overlapping equal-bit pairs (00 / 11) are
// counted. When the last bit lands, the controller reports the count and a
// threshold alarm, and it raises a one-cycle done pulse.

module pair_scan_ctrl #(
    parameter int LEN    = 16,
    parameter int CNT_W  = 5,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             inbits,
    output logic             bit_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_count,
    output logic             alarm
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The bit counter only has to index 0..LEN-1 within a scan.
    localparam int               BC_W     = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [BC_W-1:0]  LAST_IDX = BC_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state_reg, state_next;
    logic [BC_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic             hold_valid_reg, hold_valid_next;
    logic             hold_bit_reg, hold_bit_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             alarm_reg, alarm_next;
    logic             busy_reg, done_reg;

    // Next-state, pair-history and counter logic for one cycle.
    // Abort is checked before the bit handshake. If abort arrives with the
    // final bit, the scan is dropped. That bit is not counted, and the alarm
    // keeps the value cleared at start.
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        hold_valid_next = hold_valid_reg;
        hold_bit_next   = hold_bit_reg;
        count_next      = count_reg;
        alarm_next      = alarm_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next      = ST_RUN;
                    bit_cnt_next    = '0;
                    hold_valid_next = 1'b0;
                    hold_bit_next   = 1'b0;
                    count_next      = '0;
                    alarm_next      = 1'b0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (bit_valid) begin
                    if (hold_valid_reg && (hold_bit_reg == inbits)) begin
                        // A pair closes; the history empties so pairs never overlap.
                        hold_valid_next = 1'b0;
                        if (count_reg != CNT_MAX) begin
                            count_next = count_reg + 1'b1;
                        end
                    end else begin
                        hold_valid_next = 1'b1;
                        hold_bit_next   = inbits;
                    end
                    if (bit_cnt_reg == LAST_IDX) begin
                        state_next   = ST_DONE;
                        bit_cnt_next = '0;
                        alarm_next   = ({{(32-CNT_W){1'b0}}, count_next} >= 32'(THRESH));
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, history and result registers, with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= '0;
            hold_valid_reg <= 1'b0;
            hold_bit_reg   <= 1'b0;
            count_reg      <= '0;
            alarm_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            hold_valid_reg <= hold_valid_next;
            hold_bit_reg   <= hold_bit_next;
            count_reg      <= count_next;
            alarm_reg      <= alarm_next;
        end
    end

    // Status flags are registered decodes of the next state. They change
    // together with state_reg and always match it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next == ST_RUN);
            done_reg <= (state_next == ST_DONE);
        end
    end

    assign bit_ready  = busy_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign pair_count = count_reg;
    assign alarm      = alarm_reg;

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Directed bench for pair_scan_ctrl with LEN=8, CNT_W=4, THRESH=3.
// Inputs change 1 time unit after a rising edge, and outputs are checked at
// that same point.

module tb_pair_scan_ctrl;

    localparam int LEN    = 8;
    localparam int CNT_W  = 4;
    localparam int THRESH = 3;

    logic             clk;
    logic             reset;
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             inbits;
    logic             bit_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pair_count;
    logic             alarm;

    int checks = 0;
    int passed = 0;

    pair_scan_ctrl #(.LEN(LEN), .CNT_W(CNT_W), .THRESH(THRESH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .bit_valid  (bit_valid),
        .inbits     (inbits),
        .bit_ready  (bit_ready),
        .busy       (busy),
        .done       (done),
        .pair_count (pair_count),
        .alarm      (alarm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        inbits    = b;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends bits[7] first through bits[1], then checks that done has not
    // yet pulsed before the eighth bit goes in.
    task automatic send_first7(input logic [7:0] bits, input string tag);
        for (int i = 7; i >= 1; i--) begin
            send_bit(bits[i]);
        end
        check({tag, "_no_early_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        bit_valid = 1'b0;
        inbits    = 1'b0;
        tick();
        tick();
        check("rst_busy",  {31'b0, busy},      32'd0);
        check("rst_ready", {31'b0, bit_ready}, 32'd0);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_count", {28'b0, pair_count}, 32'd0);
        check("rst_alarm", {31'b0, alarm},     32'd0);
        reset = 1'b0;

        // abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort_busy", {31'b0, busy}, 32'd0);

        // 1: all ones -> 4 pairs, alarm set
        do_start();
        check("t1_busy",  {31'b0, busy},      32'd1);
        check("t1_ready", {31'b0, bit_ready}, 32'd1);
        send_first7(8'hFF, "t1");
        send_bit(1'b1);
        check("t1_done",  {31'b0, done},       32'd1);
        check("t1_busy_in_done", {31'b0, busy}, 32'd0);
        check("t1_count", {28'b0, pair_count}, 32'd4);
        check("t1_alarm", {31'b0, alarm},      32'd1);
        $display("t1 all-ones count=%0d alarm=%0b", pair_count, alarm);
        tick();
        check("t1_done_clear", {31'b0, done}, 32'd0);
        check("t1_hold_count", {28'b0, pair_count}, 32'd4);

        // 2: alternating -> no pairs
        do_start();
        check("t2_clear_alarm", {31'b0, alarm}, 32'd0);
        send_first7(8'b01010101, "t2");
        send_bit(1'b1);
        check("t2_done",  {31'b0, done},       32'd1);
        check("t2_count", {28'b0, pair_count}, 32'd0);
        check("t2_alarm", {31'b0, alarm},      32'd0);
        $display("t2 alternating count=%0d alarm=%0b", pair_count, alarm);
        tick();
        check("t2_single_done", {31'b0, done}, 32'd0);

        // 3: 0,0,1, gap of two, 0,0,1,1,1 -> 3 pairs
        do_start();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        tick();
        tick();
        check("t3_gap_ready", {31'b0, bit_ready}, 32'd1);
        check("t3_gap_count", {28'b0, pair_count}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t3_no_early_done", {31'b0, done}, 32'd0);
        send_bit(1'b1);
        check("t3_done",  {31'b0, done},       32'd1);
        check("t3_count", {28'b0, pair_count}, 32'd3);
        check("t3_alarm", {31'b0, alarm},      32'd1);
        $display("t3 gapped count=%0d alarm=%0b", pair_count, alarm);
        tick();

        // 4: three bits then abort
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy",  {31'b0, busy},       32'd0);
        check("t4_ready", {31'b0, bit_ready},  32'd0);
        check("t4_done",  {31'b0, done},       32'd0);
        check("t4_count", {28'b0, pair_count}, 32'd1);
        tick();
        check("t4_done_later", {31'b0, done}, 32'd0);
        $display("t4 abort count=%0d", pair_count);

        // 5: start re-pulsed during RUN is ignored
        do_start();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        start = 1'b1;
        send_bit(1'b0);
        start = 1'b0;
        check("t5_busy_after_restart", {31'b0, busy}, 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t5_no_early_done", {31'b0, done}, 32'd0);
        send_bit(1'b0);
        check("t5_done",  {31'b0, done},       32'd1);
        check("t5_count", {28'b0, pair_count}, 32'd3);
        $display("t5 restart-ignored count=%0d", pair_count);
        tick();

        // 6: reset mid-scan after 5 bits, then a clean scan of zeros
        do_start();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
        end
        check("t6_pre_reset_count", {28'b0, pair_count}, 32'd2);
        bit_valid = 1'b1;
        inbits    = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_busy",  {31'b0, busy},       32'd0);
        check("t6_rst_ready", {31'b0, bit_ready},  32'd0);
        check("t6_rst_count", {28'b0, pair_count}, 32'd0);
        bit_valid = 1'b0;
        tick();
        reset = 1'b0;
        do_start();
        send_first7(8'h00, "t6");
        send_bit(1'b0);
        check("t6_done",  {31'b0, done},       32'd1);
        check("t6_count", {28'b0, pair_count}, 32'd4);
        $display("t6 post-reset count=%0d", pair_count);
        tick();

        // 7: start+abort together in IDLE takes start; abort on final bit wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t7_start_wins", {31'b0, busy}, 32'd1);
        check("t7_alarm_cleared", {31'b0, alarm}, 32'd0);
        send_first7(8'hFF, "t7");
        abort = 1'b1;
        send_bit(1'b1);
        abort = 1'b0;
        check("t7_done",  {31'b0, done},       32'd0);
        check("t7_busy",  {31'b0, busy},       32'd0);
        check("t7_count", {28'b0, pair_count}, 32'd3);
        check("t7_alarm", {31'b0, alarm},      32'd0);
        $display("t7 abort-on-last count=%0d", pair_count);
        tick();
        check("t7_done_later", {31'b0, done}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
